// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, register-file and ALU bus of the issue controller
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              instrValid;
  logic              instrReady;
  logic              instrOp;
  logic [ADDR_W-1:0] instrRa;
  logic [ADDR_W-1:0] instrRb;
  logic [ADDR_W-1:0] instrRd;
  logic [ADDR_W-1:0] rfRdAddr;
  logic [DATA_W-1:0] rfRdData;
  logic              rfWrEn;
  logic [ADDR_W-1:0] rfWrAddr;
  logic [DATA_W-1:0] rfWrData;
  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  logic              aluSelect;
  logic [DATA_W-1:0] aluResult;

  modport master (
    input  instrValid, instrOp, instrRa, instrRb, instrRd, rfRdData, aluResult,
    output instrReady, rfRdAddr, rfWrEn, rfWrAddr, rfWrData, aluA, aluB, aluSelect
  );

  modport slave (
    output instrValid, instrOp, instrRa, instrRb, instrRd, rfRdData, aluResult,
    input  instrReady, rfRdAddr, rfWrEn, rfWrAddr, rfWrData, aluA, aluB, aluSelect
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - five-state issue controller: fetch two operands, run the ALU, write back
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_issue_ctrl_if.master bus,
  output logic             done,
  output logic [CNT_W-1:0] retiredCount
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WRITE} state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_sel_q, alu_sel_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rb_d      = rb_q;
    rd_d      = rd_q;
    rd_addr_d = rd_addr_q;
    op_a_d    = op_a_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (bus.instrValid) begin
          op_d      = bus.instrOp;
          rb_d      = bus.instrRb;
          rd_d      = bus.instrRd;
          rd_addr_d = bus.instrRa;
          state_d   = RD_A;
        end
      end
      RD_A: begin
        rd_addr_d = rb_q;
        state_d   = RD_B;
      end
      RD_B: begin
        op_a_d  = bus.rfRdData;
        state_d = EXEC;
      end
      // Operand B goes straight from the read port into the ALU operand register.
      EXEC: begin
        alu_a_d   = op_a_q;
        alu_b_d   = bus.rfRdData;
        alu_sel_d = op_q;
        state_d   = WRITE;
      end
      WRITE: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      rb_q      <= '0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      op_a_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rb_q      <= rb_d;
      rd_q      <= rd_d;
      rd_addr_q <= rd_addr_d;
      op_a_q    <= op_a_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      retired_q <= retired_d;
    end
  end

  // Decoded from the state register so reset forces ready high and write/done low at once.
  assign bus.instrReady = (state_q == IDLE);
  assign bus.rfWrEn     = (state_q == WRITE);
  assign done           = (state_q == WRITE);
  assign bus.rfRdAddr   = rd_addr_q;
  assign bus.rfWrAddr   = rd_q;
  assign bus.rfWrData   = bus.aluResult;
  assign bus.aluA       = alu_a_q;
  assign bus.aluB       = alu_b_q;
  assign bus.aluSelect  = alu_sel_q;
  assign retiredCount   = retired_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        done;
  logic [15:0] retiredCount;
  logic        rf_load = 1'b1;
  logic [7:0]  rf [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_count = 0;

  alu_issue_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  alu_issue_ctrl #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .done         (done),
    .retiredCount (retiredCount)
  );

  always #5 clk = ~clk;

  // Bench ALU: add, or compare-equal returning 1/0.
  assign bus.aluResult = bus.aluSelect ? {7'd0, bus.aluA == bus.aluB} : bus.aluA + bus.aluB;

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'd0;
      rf[1] <= 8'd5;
      rf[2] <= 8'd7;
      rf[4] <= 8'd200;
      rf[5] <= 8'd100;
      rf[7] <= 8'd9;
      bus.rfRdData <= 8'd0;
    end else begin
      bus.rfRdData <= rf[bus.rfRdAddr];
      if (bus.rfWrEn) rf[bus.rfWrAddr] <= bus.rfWrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge with the controller in IDLE.
  task automatic run_instr(input logic op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] ew);
    check("ready_before", {31'd0, bus.instrReady}, 1);
    bus.instrValid = 1'b1;
    bus.instrOp = op;
    bus.instrRa = ra;
    bus.instrRb = rb;
    bus.instrRd = rd;
    @(posedge clk);
    #1;
    bus.instrValid = 1'b0;
    bus.instrOp = ~op;
    bus.instrRa = ~ra;
    bus.instrRb = ~rb;
    bus.instrRd = ~rd;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("rd_addr_a", {28'd0, bus.rfRdAddr}, {28'd0, ra});
        check("ready_busy", {31'd0, bus.instrReady}, 0);
      end
      if (c == 2) check("rd_addr_b", {28'd0, bus.rfRdAddr}, {28'd0, rb});
      if (c < 4) check("done_early", {31'd0, done}, 0);
      if (c == 4) begin
        check("done_write", {31'd0, done}, 1);
        check("wr_en", {31'd0, bus.rfWrEn}, 1);
        check("wr_addr", {28'd0, bus.rfWrAddr}, {28'd0, rd});
        check("wr_data", {24'd0, bus.rfWrData}, {24'd0, ew});
        check("alu_a", {24'd0, bus.aluA}, {24'd0, ea});
        check("alu_b", {24'd0, bus.aluB}, {24'd0, eb});
        check("alu_sel", {31'd0, bus.aluSelect}, {31'd0, op});
        exp_count++;
      end
      if (c == 5) begin
        check("done_after", {31'd0, done}, 0);
        check("wr_en_after", {31'd0, bus.rfWrEn}, 0);
        check("retired", {16'd0, retiredCount}, exp_count);
        check("alu_a_hold", {24'd0, bus.aluA}, {24'd0, ea});
        check("rf_written", {24'd0, rf[rd]}, {24'd0, ew});
      end
    end
  endtask

  initial begin
    logic changed;
    logic saw_done;
    bus.instrValid = 1'b0;
    bus.instrOp = 1'b0;
    bus.instrRa = 4'd0;
    bus.instrRb = 4'd0;
    bus.instrRd = 4'd0;
    repeat (3) @(negedge clk);
    rf_load = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, bus.instrReady}, 1);
    check("rst_wr_en", {31'd0, bus.rfWrEn}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_count", {16'd0, retiredCount}, 0);
    changed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.instrReady || bus.rfWrEn || done || retiredCount != 16'd0) changed = 1'b1;
    end
    check("idle_stable", {31'd0, changed}, 0);

    run_instr(1'b0, 4'd1, 4'd2, 4'd3, 8'd5, 8'd7, 8'd12);
    run_instr(1'b0, 4'd4, 4'd5, 4'd4, 8'd200, 8'd100, 8'd44);
    run_instr(1'b0, 4'd4, 4'd4, 4'd6, 8'd44, 8'd44, 8'd88);
    run_instr(1'b1, 4'd7, 4'd7, 4'd11, 8'd9, 8'd9, 8'd1);

    for (int k = 0; k < 15; k++) begin
      check("bp_ready", {31'd0, bus.instrReady}, (k % 5 == 0) ? 1 : 0);
      check("bp_done", {31'd0, done}, (k % 5 == 4) ? 1 : 0);
      bus.instrValid = 1'b1;
      bus.instrOp = 1'b0;
      if (k % 5 == 0) begin
        bus.instrRa = 4'd1;
        bus.instrRb = 4'd2;
        bus.instrRd = 4'(8 + k / 5);
      end else begin
        bus.instrRa = 4'd5;
        bus.instrRb = 4'd5;
        bus.instrRd = 4'd15;
      end
      @(negedge clk);
    end
    bus.instrValid = 1'b0;
    exp_count += 3;
    @(negedge clk);
    check("bp_count", {16'd0, retiredCount}, exp_count);
    check("bp_r8", {24'd0, rf[8]}, 12);
    check("bp_r9", {24'd0, rf[9]}, 12);
    check("bp_r10", {24'd0, rf[10]}, 12);
    check("bp_r15", {24'd0, rf[15]}, 0);

    bus.instrValid = 1'b1;
    bus.instrOp = 1'b0;
    bus.instrRa = 4'd1;
    bus.instrRb = 4'd2;
    bus.instrRd = 4'd12;
    @(posedge clk);
    #1;
    bus.instrValid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_ready", {31'd0, bus.instrReady}, 1);
    check("mid_wr_en", {31'd0, bus.rfWrEn}, 0);
    check("mid_done", {31'd0, done}, 0);
    check("mid_count", {16'd0, retiredCount}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || bus.rfWrEn) saw_done = 1'b1;
    end
    check("mid_no_write", {31'd0, saw_done}, 0);
    check("mid_r12", {24'd0, rf[12]}, 0);
    check("mid_count_after", {16'd0, retiredCount}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
